// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory responder.
//   - RV32 load/store width codes (funct3) and store aliases.
//   - Responder FSM state encoding.
//   - Width of the WAIT-state down-counter.
//   - funct3_ok(): checks whether a width code is legal for a load or a store.
package rv_mem_pkg;

  // Load width codes. Stores reuse the same three codes for b/h/w.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = F3_LB;
  localparam logic [2:0] F3_SH  = F3_LH;
  localparam logic [2:0] F3_SW  = F3_LW;

  // Wide enough for a WAIT count of up to 15 cycles.
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Unsigned widths only exist for loads; codes 011/110/111 are never legal.
  function automatic logic funct3_ok(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LH, F3_LW: return 1'b1;
      F3_LBU, F3_LHU:      return !is_store;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane steering for the data-memory responder (purely combinational).
// Ports:
//   funct3      in   3   width code of the access
//   lane        in   2   byte offset inside the word (already aligned for h/w)
//   wdata       in  32   store data, low-aligned
//   byte_en     out  4   per-byte write enable for the addressed word
//   wdata_lane  out 32   store data replicated into every candidate lane
//   rdata_word  in  32   raw word read from the RAM
//   rdata_ext   out 32   selected lane, sign- or zero-extended
module dmem_lane_unit (
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  input  logic [31:0] rdata_word,
  output logic [31:0] rdata_ext
);
  import rv_mem_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store side: the data is copied into every lane of its width so the
  // byte enables alone decide which bytes of the word are overwritten.
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = 32'd0;
    case (funct3)
      F3_SB: begin
        byte_en    = 4'b0001 << lane;
        wdata_lane = {4{wdata[7:0]}};
      end
      F3_SH: begin
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      F3_SW: begin
        byte_en    = 4'b1111;
        wdata_lane = wdata;
      end
      default: ;
    endcase
  end

  // Load side: pick the addressed byte/half, then extend by the width code.
  always_comb begin
    case (lane)
      2'd0:    byte_sel = rdata_word[7:0];
      2'd1:    byte_sel = rdata_word[15:8];
      2'd2:    byte_sel = rdata_word[23:16];
      default: byte_sel = rdata_word[31:24];
    endcase
    half_sel = lane[1] ? rdata_word[31:16] : rdata_word[15:0];

    case (funct3)
      F3_LB:   rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   rdata_ext = {{16{half_sel[15]}}, half_sel};
      F3_LW:   rdata_ext = rdata_word;
      F3_LBU:  rdata_ext = {24'd0, byte_sel};
      F3_LHU:  rdata_ext = {16'd0, half_sel};
      default: rdata_ext = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder between the pipeline memory stage and a word-organised
// data RAM. One request is accepted on a valid/ready channel. The responder
// then waits WAIT_CYCLES cycles and returns one response: extended load data,
// a store acknowledge, or an error.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   : unaligned half/word accesses respond with rsp_err=1, no write.
//   undefined : low address bits are masked to natural alignment.
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (word index = req_addr[31:2])
//   WAIT_CYCLES  cycles spent in WAIT between accept and response (0..15)
// Ports:
//   clk, reset                      clock; asynchronous active-high reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata     store flag, byte address, low-aligned data
//   req_funct3                      RV32 width code
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_err              load result (0 for stores/errors), error flag
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  import rv_mem_pkg::*;

  localparam int ADDR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
    WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t                state;
  state_t                next_state;
  logic [WAIT_CNT_W-1:0] wait_cnt;

  logic                  lat_we;
  logic [31:0]           lat_addr;
  logic [31:0]           lat_wdata;
  logic [2:0]            lat_funct3;

  logic                  op_we;
  logic [31:0]           op_addr;
  logic [31:0]           op_wdata;
  logic [2:0]            op_funct3;

  logic                  is_half;
  logic                  is_word;
  logic                  misaligned;
  logic                  range_bad;
  logic                  op_err;
  logic [1:0]            eff_lane;
  logic [ADDR_W-1:0]     ram_idx;
  logic                  enter_resp;
  logic                  ram_we;

  logic [31:0]           mem [0:DEPTH_WORDS-1];
  logic [31:0]           raw_word;
  logic [3:0]            byte_en;
  logic [31:0]           wdata_lane;
  logic [31:0]           rdata_ext;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  // With WAIT_CYCLES==0 the RAM access happens on the accept edge itself,
  // before the latch holds the request, so in IDLE the live inputs are used.
  always_comb begin
    if (state == ST_IDLE) begin
      op_we     = req_we;
      op_addr   = req_addr;
      op_wdata  = req_wdata;
      op_funct3 = req_funct3;
    end else begin
      op_we     = lat_we;
      op_addr   = lat_addr;
      op_wdata  = lat_wdata;
      op_funct3 = lat_funct3;
    end
  end

  // Error decode and effective byte lane. In the masking build a half drops
  // addr[0] and a word drops addr[1:0]; the trap build rejects them instead.
  always_comb begin
    is_half    = (op_funct3 == F3_LH) || (op_funct3 == F3_LHU);
    is_word    = (op_funct3 == F3_LW);
    misaligned = (is_half && op_addr[0]) || (is_word && (op_addr[1:0] != 2'b00));
    range_bad  = ({2'b00, op_addr[31:2]} >= 32'(DEPTH_WORDS));
`ifdef DMEM_MISALIGN_TRAP_EN
    op_err   = !funct3_ok(op_we, op_funct3) || range_bad || misaligned;
    eff_lane = op_addr[1:0];
`else
    op_err   = !funct3_ok(op_we, op_funct3) || range_bad;
    eff_lane = op_addr[1:0];
    if (is_word) begin
      eff_lane = 2'b00;
    end else if (is_half) begin
      eff_lane = {op_addr[1], 1'b0};
    end
`endif
  end

  assign ram_idx  = op_addr[ADDR_W+1:2];
  assign raw_word = mem[ram_idx];

  dmem_lane_unit u_lane (
    .funct3     (op_funct3),
    .lane       (eff_lane),
    .wdata      (op_wdata),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .rdata_word (raw_word),
    .rdata_ext  (rdata_ext)
  );

  // Next-state logic. WAIT leaves once the counter has run down to zero, so
  // the FSM spends exactly WAIT_CYCLES cycles there.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == '0) begin
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // The RAM is touched only on the edge that enters RESP. That edge is the
  // commit point: a store still in WAIT when reset hits is simply dropped.
  assign enter_resp = (next_state == ST_RESP) && (state != ST_RESP);
  assign ram_we     = enter_resp && op_we && !op_err && !reset;

  // State register, request latch, wait counter and registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_funct3 <= 3'd0;
      rsp_rdata  <= 32'd0;
      rsp_err    <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_IDLE && req_valid) begin
        lat_we     <= req_we;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
        lat_funct3 <= req_funct3;
        wait_cnt   <= WAIT_INIT;
      end else if (state == ST_WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
      end
      if (enter_resp) begin
        rsp_err   <= op_err;
        rsp_rdata <= (op_err || op_we) ? 32'd0 : rdata_ext;
      end
    end
  end

  // RAM array: not reset, byte-granular writes.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[ram_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder. A byte-addressed reference
// memory predicts every response from the load/store rules directly.
// Honours DMEM_MISALIGN_TRAP_EN the same way the design does.
module tb_data_mem_responder;
  import rv_mem_pkg::*;

  localparam int TB_DEPTH = 256;
  localparam int TB_WAIT  = 3;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl [TB_DEPTH*4];

  data_mem_responder #(
    .DEPTH_WORDS (TB_DEPTH),
    .WAIT_CYCLES (TB_WAIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something upstream never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value with its prediction and count the outcome.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: byte-addressed memory, little-endian words.
  task automatic modelAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] f3, output logic exp_err, output logic [31:0] exp_rdata);
    logic [31:0] sz;
    logic [31:0] a;
    logic        bad;
    logic [31:0] val;
    exp_err   = 1'b0;
    exp_rdata = 32'd0;
    bad = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    sz  = 32'd1 << f3[1:0];
    a   = addr;
    if (!bad) begin
`ifdef DMEM_MISALIGN_TRAP_EN
      if ((addr & (sz - 32'd1)) != 32'd0) bad = 1'b1;
`else
      a = addr & ~(sz - 32'd1);
`endif
    end
    if ((addr >> 2) >= 32'(TB_DEPTH)) bad = 1'b1;
    if (bad) begin
      exp_err = 1'b1;
    end else if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (32'(i) < sz) mdl[a + 32'(i)] = wdata[8*i +: 8];
      end
    end else begin
      val = 32'd0;
      for (int i = 0; i < 4; i++) begin
        if (32'(i) < sz) val[8*i +: 8] = mdl[a + 32'(i)];
      end
      if (!f3[2] && sz < 32'd4 && val[8*sz - 1]) val = val | (32'hFFFF_FFFF << (8*sz));
      exp_rdata = val;
    end
  endtask

  // Present a request for one accept edge, then keep req_valid high with junk
  // so the design has to ignore it while busy.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] f3);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    @(posedge clk); #1;
    req_we     = 1'b1;
    req_addr   = $urandom_range(0, TB_DEPTH*4 - 1);
    req_wdata  = $urandom;
    req_funct3 = F3_SW;
  endtask

  // Full transaction: predict, issue, wait (bounded), check, hand back.
  task automatic runTxn(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        output logic [31:0] obs_rdata, output logic obs_err);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          cyc;
    modelAccess(we, addr, wdata, f3, exp_err, exp_rdata);
    checkOutput({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
    applyStimulus(we, addr, wdata, f3);
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    // Edges from the accept edge (inclusive) to the one raising rsp_valid.
    checkOutput({tag, " latency"}, 32'(cyc + 1), 32'(TB_WAIT + 1));
    obs_rdata = rsp_rdata;
    obs_err   = rsp_err;
    checkOutput({tag, " err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    checkOutput({tag, " rdata"}, rsp_rdata, exp_rdata);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] held_rdata;
    logic        held_err;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          cyc;

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_funct3 = 3'd0;
    rsp_ready  = 1'b0;

    // Reset state, during and after reset.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("post-reset rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // Give every word a known value so the model covers the whole RAM.
    for (int w = 0; w < TB_DEPTH; w++) begin
      runTxn("preload", 1'b1, 32'(w * 4), $urandom, F3_SW, rd, er);
    end

    // Word store then load.
    runTxn("t1 sw", 1'b1, 32'h40, 32'hCAFE_BABE, F3_SW, rd, er);
    runTxn("t1 lw", 1'b0, 32'h40, 32'd0, F3_LW, rd, er);
    checkOutput("t1 lw const", rd, 32'hCAFE_BABE);

    // Byte lanes.
    runTxn("t2 sb", 1'b1, 32'h41, 32'h80, F3_SB, rd, er);
    runTxn("t2 lb", 1'b0, 32'h41, 32'd0, F3_LB, rd, er);
    checkOutput("t2 lb const", rd, 32'hFFFF_FF80);
    runTxn("t2 lbu", 1'b0, 32'h41, 32'd0, F3_LBU, rd, er);
    checkOutput("t2 lbu const", rd, 32'h0000_0080);
    runTxn("t2 lw", 1'b0, 32'h40, 32'd0, F3_LW, rd, er);
    checkOutput("t2 lw const", rd, 32'hCAFE_80BE);

    // Errors: out of range load, illegal store width leaves RAM alone.
    runTxn("t4 lw range", 1'b0, 32'(4 * TB_DEPTH), 32'd0, F3_LW, rd, er);
    checkOutput("t4 range err", {31'd0, er}, 32'd1);
    checkOutput("t4 range rdata", rd, 32'd0);
    runTxn("t4 st f3=100", 1'b1, 32'h40, 32'hDEAD_BEEF, F3_LBU, rd, er);
    checkOutput("t4 store err", {31'd0, er}, 32'd1);
    runTxn("t4 lw after", 1'b0, 32'h40, 32'd0, F3_LW, rd, er);
    checkOutput("t4 ram unchanged", rd, 32'hCAFE_80BE);

    // Misaligned half.
    runTxn("t5 sh", 1'b1, 32'h42, 32'h1234, F3_SH, rd, er);
    runTxn("t5 lh", 1'b0, 32'h43, 32'd0, F3_LH, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    checkOutput("t5 lh trap err", {31'd0, er}, 32'd1);
`else
    checkOutput("t5 lh masked", rd, 32'h0000_1234);
`endif

    // Latency and backpressure: response held for 5 cycles with junk requests.
    modelAccess(1'b0, 32'h40, 32'd0, F3_LW, exp_err, exp_rdata);
    applyStimulus(1'b0, 32'h40, 32'd0, F3_LW);
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("t3 latency", 32'(cyc + 1), 32'(TB_WAIT + 1));
    checkOutput("t3 rdata", rsp_rdata, exp_rdata);
    held_rdata = rsp_rdata;
    held_err   = rsp_err;
    for (int k = 0; k < 5; k++) begin
      req_addr  = 32'h40;
      req_wdata = $urandom;
      @(posedge clk); #1;
      checkOutput("t3 hold valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("t3 hold rdata", rsp_rdata, held_rdata);
      checkOutput("t3 hold err", {31'd0, rsp_err}, {31'd0, held_err});
      checkOutput("t3 hold req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    checkOutput("t3 release valid", {31'd0, rsp_valid}, 32'd0);
    runTxn("t3 junk ignored", 1'b0, 32'h40, 32'd0, F3_LW, rd, er);

    // Randomised traffic, mostly in range, every width code.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, TB_DEPTH*4 - 1));
      runTxn("random", 1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)), rd, er);
    end

    // Reset while a store sits in WAIT: the store must be dropped.
    applyStimulus(1'b1, 32'h80, 32'h1111_1111, F3_SW);
    #2 reset = 1'b1;
    req_valid = 1'b0;
    #2 reset = 1'b0;
    checkOutput("t6 req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("t6 rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("t6 rsp_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    runTxn("t6 lw prior", 1'b0, 32'h80, 32'd0, F3_LW, rd, er);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
